// File: rtl/module_arbitro_de_bus.sv
// Two-master round-robin arbiter for the single-beat peripheral/memory data bus.
// Optional macro BUS_LOCK_EN adds per-master lock inputs for chained transactions.
module module_arbitro_de_bus #(
    parameter int RD_LAT = 1,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              m0_req_i,
    input  logic              m0_we_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [DATA_W-1:0] m0_data_i,
    output logic              m0_gnt_o,
    output logic              m0_ack_o,
    output logic [DATA_W-1:0] m0_rdata_o,
    input  logic              m1_req_i,
    input  logic              m1_we_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [DATA_W-1:0] m1_data_i,
    output logic              m1_gnt_o,
    output logic              m1_ack_o,
    output logic [DATA_W-1:0] m1_rdata_o,
`ifdef BUS_LOCK_EN
    input  logic              m0_lock_i,
    input  logic              m1_lock_i,
`endif
    output logic              bus_we_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [DATA_W-1:0] bus_do_o,
    input  logic [DATA_W-1:0] bus_di_i,
    output logic              busy_o
);

    typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_DONE} state_t;

    localparam logic [2:0] LP_LAT = 3'(RD_LAT);

    state_t              r_state;
    state_t              w_next;
    logic                r_last_gnt;
    logic                r_sel;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_data;
    logic [2:0]          r_cnt;
    logic [DATA_W-1:0]   r_m0_rdata;
    logic [DATA_W-1:0]   r_m1_rdata;

    logic                w_any_req;
    logic                w_pick;
    logic                w_src;
    logic                w_last_beat;
    logic                w_relock;

    assign w_any_req   = m0_req_i | m1_req_i;
    // On a tie the master that did not win last time takes the bus.
    assign w_pick      = (m0_req_i & m1_req_i) ? ~r_last_gnt : m1_req_i;
    assign w_src       = (r_state == ST_IDLE) ? w_pick : r_sel;
    assign w_last_beat = r_we | (r_cnt == LP_LAT);

`ifdef BUS_LOCK_EN
    logic [2:0] r_lock_cnt;

    // Seven continuations after the arbitrated transaction caps a chain at eight.
    assign w_relock = (r_sel ? (m1_lock_i & m1_req_i) : (m0_lock_i & m0_req_i))
                      & (r_lock_cnt != 3'd7);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_lock_cnt <= 3'd0;
        end else if (r_state == ST_IDLE) begin
            r_lock_cnt <= 3'd0;
        end else if (r_state == ST_DONE && w_relock) begin
            r_lock_cnt <= r_lock_cnt + 3'd1;
        end
    end
`else
    assign w_relock = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_any_req) w_next = ST_ACCESS;
            ST_ACCESS: if (w_last_beat) w_next = ST_DONE;
            ST_DONE:   w_next = w_relock ? ST_ACCESS : ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_last_gnt <= 1'b1;
            r_sel      <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_data     <= '0;
            r_cnt      <= 3'd0;
            r_m0_rdata <= '0;
            r_m1_rdata <= '0;
        end else begin
            if ((r_state == ST_IDLE && w_any_req) || (r_state == ST_DONE && w_relock)) begin
                r_sel  <= w_src;
                r_we   <= w_src ? m1_we_i   : m0_we_i;
                r_addr <= w_src ? m1_addr_i : m0_addr_i;
                r_data <= w_src ? m1_data_i : m0_data_i;
                r_cnt  <= 3'd0;
                if (r_state == ST_IDLE) r_last_gnt <= w_pick;
            end
            // Read data is taken on the edge that closes the final access cycle.
            if (r_state == ST_ACCESS && !r_we) begin
                if (r_cnt == LP_LAT) begin
                    if (r_sel) r_m1_rdata <= bus_di_i;
                    else       r_m0_rdata <= bus_di_i;
                end else begin
                    r_cnt <= r_cnt + 3'd1;
                end
            end
        end
    end

    always_comb begin
        m0_gnt_o   = 1'b0;
        m1_gnt_o   = 1'b0;
        m0_ack_o   = 1'b0;
        m1_ack_o   = 1'b0;
        bus_we_o   = 1'b0;
        bus_addr_o = '0;
        bus_do_o   = '0;
        busy_o     = 1'b0;
        case (r_state)
            ST_ACCESS: begin
                m0_gnt_o   = ~r_sel;
                m1_gnt_o   = r_sel;
                bus_we_o   = r_we;
                bus_addr_o = r_addr;
                bus_do_o   = r_data;
                busy_o     = 1'b1;
            end
            ST_DONE: begin
                m0_gnt_o   = ~r_sel;
                m1_gnt_o   = r_sel;
                m0_ack_o   = ~r_sel;
                m1_ack_o   = r_sel;
                bus_addr_o = r_addr;
                bus_do_o   = r_data;
                busy_o     = 1'b1;
            end
            default: ;
        endcase
    end

    assign m0_rdata_o = r_m0_rdata;
    assign m1_rdata_o = r_m1_rdata;

endmodule

// File: tb/tb_module_arbitro_de_bus.sv
// Directed plus randomized bench for module_arbitro_de_bus against a transaction-level model.
module tb_module_arbitro_de_bus;
    localparam int RD_LAT = 1;
    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          m0_req = 1'b0, m0_we = 1'b0;
    logic [AW-1:0] m0_addr = '0;
    logic [DW-1:0] m0_data = '0;
    logic          m1_req = 1'b0, m1_we = 1'b0;
    logic [AW-1:0] m1_addr = '0;
    logic [DW-1:0] m1_data = '0;
    logic [DW-1:0] bus_di = '0;
    logic          m0_gnt, m0_ack, m1_gnt, m1_ack, bus_we, busy;
    logic [DW-1:0] m0_rdata, m1_rdata, bus_do;
    logic [AW-1:0] bus_addr;

    always #5 clk = ~clk;

    module_arbitro_de_bus #(.RD_LAT(RD_LAT), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_data_i(m0_data),
        .m0_gnt_o(m0_gnt), .m0_ack_o(m0_ack), .m0_rdata_o(m0_rdata),
        .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_data_i(m1_data),
        .m1_gnt_o(m1_gnt), .m1_ack_o(m1_ack), .m1_rdata_o(m1_rdata),
`ifdef BUS_LOCK_EN
        .m0_lock_i(1'b0), .m1_lock_i(1'b0),
`endif
        .bus_we_o(bus_we), .bus_addr_o(bus_addr), .bus_do_o(bus_do),
        .bus_di_i(bus_di), .busy_o(busy)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;

    // Transaction-level model: one active transfer described by its owner and age.
    bit            md_act;
    bit            md_sel;
    bit            md_we;
    logic [AW-1:0] md_addr;
    logic [DW-1:0] md_data;
    int            md_pos;
    bit            md_last;
    logic [DW-1:0] md_rdata [2];
    logic [0:0]    exp_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h cycle=%0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        md_act = 1'b0;
        md_pos = 0;
        md_last = 1'b1;
        md_rdata[0] = '0;
        md_rdata[1] = '0;
    endtask

    task automatic model_edge();
        int lat;
        if (!md_act) begin
            if (m0_req || m1_req) begin
                md_sel  = (m0_req && m1_req) ? !md_last : m1_req;
                md_last = md_sel;
                md_we   = md_sel ? m1_we : m0_we;
                md_addr = md_sel ? m1_addr : m0_addr;
                md_data = md_sel ? m1_data : m0_data;
                md_act  = 1'b1;
                md_pos  = 0;
            end
        end else begin
            lat = md_we ? 0 : RD_LAT;
            if (md_pos == lat + 1) begin
                md_act = 1'b0;
            end else begin
                if (md_pos == lat && !md_we) md_rdata[md_sel] = bus_di;
                md_pos++;
            end
        end
    endtask

    task automatic check_outputs();
        int  lat;
        bit  acc;
        bit  dn;
        lat = md_we ? 0 : RD_LAT;
        acc = md_act && (md_pos <= lat);
        dn  = md_act && (md_pos == lat + 1);
        chk("m0_gnt", m0_gnt, (acc || dn) && !md_sel);
        chk("m1_gnt", m1_gnt, (acc || dn) && md_sel);
        chk("m0_ack", m0_ack, dn && !md_sel);
        chk("m1_ack", m1_ack, dn && md_sel);
        chk("busy", busy, acc || dn);
        chk("bus_we", bus_we, acc && md_we);
        chk("bus_addr", bus_addr, (acc || dn) ? md_addr : '0);
        if (!dn) chk("bus_do", bus_do, acc ? md_data : '0);
        chk("m0_rdata", m0_rdata, md_rdata[0]);
        chk("m1_rdata", m1_rdata, md_rdata[1]);
        chk("gnt_onehot", m0_gnt & m1_gnt, 1'b0);
        if (md_act && md_pos == 0 && exp_q.size() > 0) chk("grant_order", m1_gnt, exp_q.pop_front());
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        model_edge();
        check_outputs();
    endtask

    task automatic set_m0(input logic req, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        m0_req = req; m0_we = we; m0_addr = a; m0_data = d;
    endtask

    task automatic set_m1(input logic req, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        m1_req = req; m1_we = we; m1_addr = a; m1_data = d;
    endtask

    task automatic mid_cycle_reset();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        #12;
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;

        // M0 single write.
        set_m0(1, 1, 32'h2008, 32'h0000_00A5);
        tick();
        chk("wr_strobe", bus_we, 1'b1);
        chk("wr_addr", bus_addr, 32'h2008);
        set_m0(0, 0, 32'h0, 32'h0);
        tick();
        chk("wr_ack_t2", m0_ack, 1'b1);
        chk("wr_strobe_off", bus_we, 1'b0);
        tick();

        // M1 read with one cycle of latency.
        bus_di = 32'hDEAD_BEEF;
        set_m1(1, 0, 32'h1004, 32'h0);
        tick();
        set_m1(0, 0, 32'h0, 32'h0);
        tick();
        tick();
        chk("rd_ack_t3", m1_ack, 1'b1);
        chk("rd_data", m1_rdata, 32'hDEAD_BEEF);
        bus_di = 32'h1234_5678;
        tick();

        // Both masters held requesting from reset: strict alternation.
        mid_cycle_reset();
        exp_q.push_back(1'b0); exp_q.push_back(1'b1);
        exp_q.push_back(1'b0); exp_q.push_back(1'b1);
        set_m0(1, 1, 32'h0000_0100, 32'h0000_0011);
        set_m1(1, 1, 32'h0000_0200, 32'h0000_0022);
        for (int i = 0; i < 12; i++) tick();
        chk("grant_queue_drained", exp_q.size(), 0);
        set_m0(0, 0, 32'h0, 32'h0);
        set_m1(0, 0, 32'h0, 32'h0);
        tick();

        // M1 requests while M0's read is in flight.
        bus_di = 32'hCAFE_0001;
        set_m0(1, 0, 32'h0000_0300, 32'h0);
        tick();
        set_m0(0, 0, 32'h0, 32'h0);
        set_m1(1, 1, 32'h0000_0400, 32'h0000_0044);
        tick();
        chk("m1_waits", m1_gnt, 1'b0);
        tick();
        tick();
        chk("m1_not_yet", m1_gnt, 1'b0);
        tick();
        chk("m1_granted", m1_gnt, 1'b1);
        set_m1(0, 0, 32'h0, 32'h0);
        tick();
        tick();

        // Reset during a write access cycle.
        set_m0(1, 1, 32'h0000_0500, 32'h0000_0055);
        tick();
        chk("pre_rst_strobe", bus_we, 1'b1);
        set_m0(0, 0, 32'h0, 32'h0);
        mid_cycle_reset();
        chk("rst_strobe_cut", bus_we, 1'b0);
        chk("rst_no_ack", m0_ack, 1'b0);
        set_m0(1, 1, 32'h0000_0504, 32'h0000_0066);
        tick();
        set_m0(0, 0, 32'h0, 32'h0);
        tick();
        chk("post_rst_ack", m0_ack, 1'b1);
        tick();

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            set_m0($urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)), $urandom(), $urandom());
            set_m1($urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)), $urandom(), $urandom());
            bus_di = $urandom();
            tick();
        end
        set_m0(0, 0, 32'h0, 32'h0);
        set_m1(0, 0, 32'h0, 32'h0);
        for (int i = 0; i < 6; i++) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
